control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/ctrl_pkg.sv | 110 +++++++++++
 rtl/alu_decoder.sv | 30 +++
 rtl/control_unit.sv | 111 +++++++++++
 tb/tb_control_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcodes,
// ALU codes, datapath select values and the per-state control word.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALU_OUT    = 2'b00;
  localparam logic [1:0] RES_MEM        = 2'b01;
  localparam logic [1:0] RES_ALU_RESULT = 2'b10;

  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLD_PC = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       pc_update;
    logic       branch;
    logic [1:0] result_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // Opcode-independent part of the Moore outputs for each state.
  function automatic ctrl_t state_outs(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.src_b      = SRCB_FOUR;
        c.result_src = RES_ALU_RESULT;
        c.pc_update  = 1'b1;
      end
      S_DECODE: begin
        c.src_a = SRCA_OLD_PC;
        c.src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        c.src_a = SRCA_RS1;
        c.src_b = SRCB_IMM;
      end
      S_MEMREAD: c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = RES_MEM;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECUTER: begin
        c.src_a  = SRCA_RS1;
        c.alu_op = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        c.src_a  = SRCA_RS1;
        c.src_b  = SRCB_IMM;
        c.alu_op = ALUOP_FUNCT;
      end
      S_ALUWB: c.reg_write = 1'b1;
      S_BEQ: begin
        c.src_a  = SRCA_RS1;
        c.alu_op = ALUOP_SUB;
        c.branch = 1'b1;
      end
      S_JAL: begin
        c.src_a     = SRCA_OLD_PC;
        c.src_b     = SRCB_FOUR;
        c.pc_update = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse alu_op plus instruction fields to an ALU operation.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7_5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type with funct7[5] subtracts; addi never does.
          3'b000:  alu_control = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle RISC-V control FSM with retired-instruction counter and a
// sticky illegal-opcode flag; dbg_state exposes the current FSM state.
module control_unit
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  op_code,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic        Zero,
  output logic        adr_src,
  output logic        mem_write,
  output logic        IR_write,
  output logic        reg_write,
  output logic        PC_write,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  imm_src,
  output logic [2:0]  alu_control,
  output logic [31:0] instr_retired,
  output logic        illegal_op,
  output logic [3:0]  dbg_state
);

  state_t state, nxt;
  ctrl_t  q;
  logic   taken, retire, legal;
  logic   unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_FETCH: nxt = S_DECODE;
      S_DECODE: begin
        case (op_code)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_R:         nxt = S_EXECUTER;
          OP_I:         nxt = S_EXECUTEI;
          OP_BR:        nxt = S_BEQ;
          OP_JAL:       nxt = S_JAL;
          default:      nxt = S_FETCH;
        endcase
      end
      S_MEMADR:                      nxt = (op_code == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:                     nxt = S_MEMWB;
      S_EXECUTER, S_EXECUTEI, S_JAL: nxt = S_ALUWB;
      default:                       nxt = S_FETCH;
    endcase
  end

  assign legal  = op_code inside {OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL};
  assign retire = state inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ};

  // Control word is registered from the next state so it always matches state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_FETCH;
      q             <= state_outs(S_FETCH);
      instr_retired <= '0;
      illegal_op    <= 1'b0;
    end else begin
      state <= nxt;
      q     <= state_outs(nxt);
      if (retire)
        instr_retired <= instr_retired + 32'd1;
      if (state == S_DECODE && !legal)
        illegal_op <= 1'b1;
    end
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      default: taken = 1'b0;
    endcase
  end

  // imm_src depends on the opcode held in the instruction register.
  always_comb begin
    imm_src = IMM_I;
    if (state == S_DECODE)
      imm_src = (op_code == OP_JAL) ? IMM_J : IMM_B;
    else if (state == S_MEMADR)
      imm_src = (op_code == OP_SW) ? IMM_S : IMM_I;
  end

  // Write enables are gated by reset directly so they drop the instant it asserts.
  assign mem_write  = q.mem_write & reset;
  assign IR_write   = q.ir_write & reset;
  assign reg_write  = q.reg_write & reset;
  assign PC_write   = (q.pc_update | (q.branch & taken)) & reset;
  assign adr_src    = q.adr_src;
  assign result_src = q.result_src;
  assign alu_src_a  = q.src_a;
  assign alu_src_b  = q.src_b;
  assign dbg_state  = state;

  alu_decoder u_alu_decoder (
    .alu_op      (q.alu_op),
    .funct3      (funct3),
    .op5         (op_code[5]),
    .funct7_5    (funct7[5]),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction phase model from the
// instruction-class cycle table, checked every cycle, plus directed literals.
module tb_control_unit;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  op_code = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic        Zero = 1'b0;
  logic        adr_src, mem_write, IR_write, reg_write, PC_write, illegal_op;
  logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0]  alu_control;
  logic [31:0] instr_retired;
  logic [3:0]  dbg_state;

  control_unit dut (
    .clk(clk), .reset(reset), .op_code(op_code), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .adr_src(adr_src), .mem_write(mem_write), .IR_write(IR_write),
    .reg_write(reg_write), .PC_write(PC_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_control(alu_control), .instr_retired(instr_retired),
    .illegal_op(illegal_op), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [3:0]  st;
    logic        adr, mw, irw, rw, pcw;
    logic [1:0]  res, sa, sb, imm;
    logic [2:0]  alu;
    logic [31:0] ret;
    logic        ill;
  } exp_t;

  exp_t        exp_cur;
  logic        exp_valid = 1'b0;
  logic [31:0] retired_m = '0;
  logic        illegal_m = 1'b0;
  state_t      ph_q[$];
  logic [3:0]  seen_st[8];
  logic        seen_rw[8], seen_pcw[8], seen_mw[8];
  logic [2:0]  seen_alu[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic is_legal(logic [6:0] op);
    return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
  endfunction

  // Cycle sequence of one instruction, straight from the class table.
  function automatic void build_phases(logic [6:0] op);
    ph_q = {};
    ph_q.push_back(S_FETCH);
    ph_q.push_back(S_DECODE);
    case (op)
      7'b0000011: begin ph_q.push_back(S_MEMADR); ph_q.push_back(S_MEMREAD); ph_q.push_back(S_MEMWB); end
      7'b0100011: begin ph_q.push_back(S_MEMADR); ph_q.push_back(S_MEMWRITE); end
      7'b0110011: begin ph_q.push_back(S_EXECUTER); ph_q.push_back(S_ALUWB); end
      7'b0010011: begin ph_q.push_back(S_EXECUTEI); ph_q.push_back(S_ALUWB); end
      7'b1100011: ph_q.push_back(S_BEQ);
      7'b1101111: begin ph_q.push_back(S_JAL); ph_q.push_back(S_ALUWB); end
      default: ;
    endcase
  endfunction

  function automatic exp_t spec_outs(state_t p, logic [6:0] op, logic [2:0] f3, logic [6:0] f7, logic z);
    exp_t e;
    logic [1:0] aop;
    logic pcu, br, tk;
    e = '0; aop = 2'b00; pcu = 1'b0; br = 1'b0;
    e.st = p;
    case (p)
      S_FETCH:    begin e.irw = 1; e.sb = 2'b10; e.res = 2'b10; pcu = 1; end
      S_DECODE:   begin e.sa = 2'b01; e.sb = 2'b01; e.imm = (op == 7'b1101111) ? 2'b11 : 2'b10; end
      S_MEMADR:   begin e.sa = 2'b10; e.sb = 2'b01; e.imm = (op == 7'b0100011) ? 2'b01 : 2'b00; end
      S_MEMREAD:  e.adr = 1;
      S_MEMWB:    begin e.res = 2'b01; e.rw = 1; end
      S_MEMWRITE: begin e.adr = 1; e.mw = 1; end
      S_EXECUTER: begin e.sa = 2'b10; aop = 2'b10; end
      S_EXECUTEI: begin e.sa = 2'b10; e.sb = 2'b01; aop = 2'b10; end
      S_ALUWB:    e.rw = 1;
      S_BEQ:      begin e.sa = 2'b10; aop = 2'b01; br = 1; end
      S_JAL:      begin e.sa = 2'b01; e.sb = 2'b10; pcu = 1; end
      default: ;
    endcase
    tk = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : 1'b0;
    e.pcw = pcu | (br & tk);
    if (aop == 2'b01) e.alu = 3'b001;
    else if (aop == 2'b10) begin
      case (f3)
        3'b000:  e.alu = (op[5] & f7[5]) ? 3'b001 : 3'b000;
        3'b010:  e.alu = 3'b101;
        3'b110:  e.alu = 3'b011;
        3'b111:  e.alu = 3'b010;
        default: e.alu = 3'b000;
      endcase
    end
    e.ret = retired_m;
    e.ill = illegal_m;
    return e;
  endfunction

  // compare process
  always @(negedge clk) begin
    #2;
    if (exp_valid) begin
      chk("state",       32'(dbg_state),   32'(exp_cur.st));
      chk("adr_src",     32'(adr_src),     32'(exp_cur.adr));
      chk("mem_write",   32'(mem_write),   32'(exp_cur.mw));
      chk("IR_write",    32'(IR_write),    32'(exp_cur.irw));
      chk("reg_write",   32'(reg_write),   32'(exp_cur.rw));
      chk("PC_write",    32'(PC_write),    32'(exp_cur.pcw));
      chk("result_src",  32'(result_src),  32'(exp_cur.res));
      chk("alu_src_a",   32'(alu_src_a),   32'(exp_cur.sa));
      chk("alu_src_b",   32'(alu_src_b),   32'(exp_cur.sb));
      chk("imm_src",     32'(imm_src),     32'(exp_cur.imm));
      chk("alu_control", 32'(alu_control), 32'(exp_cur.alu));
      chk("retired",     instr_retired,    exp_cur.ret);
      chk("illegal_op",  32'(illegal_op),  32'(exp_cur.ill));
    end
  end

  // driver: one instruction; stop_after>0 abandons it after that many cycles
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic z, input int stop_after);
    int n;
    build_phases(op);
    n = ph_q.size();
    if (stop_after > 0 && stop_after < n) n = stop_after;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin op_code = op; funct3 = f3; funct7 = f7; end
      Zero = z;
      exp_cur = spec_outs(ph_q[i], op, f3, f7, z);
      exp_valid = 1'b1;
      #3;
      seen_st[i] = dbg_state; seen_rw[i] = reg_write; seen_pcw[i] = PC_write;
      seen_mw[i] = mem_write; seen_alu[i] = alu_control;
    end
    if (stop_after == 0) begin
      if (is_legal(op)) retired_m = retired_m + 32'd1;
      else illegal_m = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"},     32'(dbg_state),  32'(S_FETCH));
    chk({tag, "_mem_write"}, 32'(mem_write),  0);
    chk({tag, "_reg_write"}, 32'(reg_write),  0);
    chk({tag, "_IR_write"},  32'(IR_write),   0);
    chk({tag, "_PC_write"},  32'(PC_write),   0);
    chk({tag, "_retired"},   instr_retired,   0);
    chk({tag, "_illegal"},   32'(illegal_op), 0);
  endtask

  logic [6:0] rnd_ops[8];

  initial begin
    rnd_ops[0] = 7'b0000011; rnd_ops[1] = 7'b0100011; rnd_ops[2] = 7'b0110011;
    rnd_ops[3] = 7'b0010011; rnd_ops[4] = 7'b1100011; rnd_ops[5] = 7'b1101111;
    rnd_ops[6] = 7'b0110111; rnd_ops[7] = 7'b1110011;

    // reset
    repeat (2) @(negedge clk);
    #2 check_reset_outputs("rst");
    @(posedge clk); #1 reset = 1'b1;

    // lw: five cycles, write only in the last
    run_instr(7'b0000011, 3'b010, 7'b0, 1'b0, 0);
    chk("lw_c1_state", 32'(seen_st[0]), 32'(S_FETCH));
    chk("lw_c2_state", 32'(seen_st[1]), 32'(S_DECODE));
    chk("lw_c3_state", 32'(seen_st[2]), 32'(S_MEMADR));
    chk("lw_c4_state", 32'(seen_st[3]), 32'(S_MEMREAD));
    chk("lw_c5_state", 32'(seen_st[4]), 32'(S_MEMWB));
    chk("lw_rw_c4",    32'(seen_rw[3]), 0);
    chk("lw_rw_c5",    32'(seen_rw[4]), 1);
    @(posedge clk); #1 chk("lw_retired", instr_retired, 32'd1);

    run_instr(7'b0110011, 3'b000, 7'b0100000, 1'b0, 0);
    chk("sub_alu", 32'(seen_alu[2]), 32'(3'b001));
    run_instr(7'b0110011, 3'b000, 7'b0000000, 1'b0, 0);
    chk("add_alu", 32'(seen_alu[2]), 32'(3'b000));
    run_instr(7'b1100011, 3'b000, 7'b0, 1'b1, 0);
    chk("beq_z1_pcw", 32'(seen_pcw[2]), 1);
    run_instr(7'b1100011, 3'b000, 7'b0, 1'b0, 0);
    chk("beq_z0_pcw", 32'(seen_pcw[2]), 0);
    run_instr(7'b1100011, 3'b001, 7'b0, 1'b0, 0);
    chk("bne_z0_pcw", 32'(seen_pcw[2]), 1);

    // unsupported opcode
    run_instr(7'b0110111, 3'b000, 7'b0, 1'b0, 0);
    chk("ill_c2_state", 32'(seen_st[1]), 32'(S_DECODE));
    @(posedge clk); #1;
    chk("ill_state_fetch", 32'(dbg_state), 32'(S_FETCH));
    chk("ill_flag", 32'(illegal_op), 1);
    chk("ill_retired", instr_retired, 32'd6);
    run_instr(7'b0010011, 3'b111, 7'b0, 1'b0, 0);
    chk("ill_sticky", 32'(illegal_op), 1);

    // counter wrap across a store
    @(posedge clk); #1;
    force dut.instr_retired = 32'hFFFF_FFFF;
    #1 release dut.instr_retired;
    retired_m = 32'hFFFF_FFFF;
    run_instr(7'b0100011, 3'b010, 7'b0, 1'b0, 0);
    @(posedge clk); #1 chk("sw_wrap", instr_retired, 32'd0);
    run_instr(7'b1101111, 3'b000, 7'b0, 1'b0, 0);
    chk("jal_pcw", 32'(seen_pcw[2]), 1);

    // randomized mix
    for (int k = 0; k < 40; k++) begin
      logic [6:0] op;
      op = rnd_ops[$urandom_range(0, 7)];
      run_instr(op, 3'($urandom_range(0, 7)), {1'b0, 1'($urandom_range(0, 1)), 5'b0},
                1'($urandom_range(0, 1)), 0);
    end

    // reset in the middle of a store
    run_instr(7'b0100011, 3'b010, 7'b0, 1'b0, 4);
    chk("sw_mw_before", 32'(seen_mw[3]), 1);
    exp_valid = 1'b0;
    reset = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    #2 check_reset_outputs("midrst_hold");
    @(posedge clk); #1 reset = 1'b1;
    retired_m = '0;
    illegal_m = 1'b0;
    run_instr(7'b0000011, 3'b010, 7'b0, 1'b0, 0);
    chk("post_rst_first", 32'(seen_st[0]), 32'(S_FETCH));
    @(posedge clk); #1 chk("post_rst_retired", instr_retired, 32'd1);

    exp_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
